// File: rtl/hazard_unit_pkg.sv
// ============================================================================
// Module      : hazard_unit_pkg
// Description : Shared definitions for the ID-stage hazard/forwarding unit:
//               forwarding-select codes, FSM encoding, tracker entry layout.
//               Optional macro HAZARD_CHECK_EN adds rs/rt to tracker entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_unit_pkg;

  localparam int HZ_RW = 5;

  // Forwarding source selects
  localparam logic [1:0] CTRL_REG = 2'd0;
  localparam logic [1:0] CTRL_EX  = 2'd1;
  localparam logic [1:0] CTRL_MEM = 2'd2;
  localparam logic [1:0] CTRL_WB  = 2'd3;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_BUBBLE = 2'd1,
    HZ_HOLD   = 2'd2
  } hz_state_e;

  // One tracked pipeline slot (EX, MEM or WB)
  typedef struct packed {
    logic             valid;
    logic [HZ_RW-1:0] dst;
    logic             regwrite;
    logic             memread;
`ifdef HAZARD_CHECK_EN
    logic [HZ_RW-1:0] rs;
    logic [HZ_RW-1:0] rt;
`endif
  } trk_entry_t;

  localparam trk_entry_t c_trk_empty = '0;

  // True when the slot holds a valid register write to src
  function automatic logic trk_hit(input trk_entry_t e, input logic [HZ_RW-1:0] src);
    return e.valid && e.regwrite && (e.dst == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// ============================================================================
// Module      : hazard_fwd_sel
// Description : Pure comparator choosing the forwarding source for one ID
//               source operand from the EX/MEM/WB tracker slots. The youngest
//               producer wins; loads in EX are not forwardable (load-use).
//               With HAZARD_CHECK_EN the entries carry rs/rt, unused here.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic [HZ_RW-1:0] i_src,
  input  logic             i_use,
  input  trk_entry_t       i_ex,
  input  trk_entry_t       i_mem,
  input  trk_entry_t       i_wb,
  output logic [1:0]       o_sel
);

  // Fields not involved in the select decision
  logic w_unused;
`ifdef HAZARD_CHECK_EN
  assign w_unused = ^{i_mem.memread, i_wb.memread,
                      i_ex.rs, i_ex.rt, i_mem.rs, i_mem.rt, i_wb.rs, i_wb.rt};
`else
  assign w_unused = ^{i_mem.memread, i_wb.memread};
`endif

  // Priority select EX > MEM > WB; r0 and unused operands read the regfile
  always_comb begin
    o_sel = CTRL_REG;
    if (i_use && (i_src != '0)) begin
      if (trk_hit(i_ex, i_src) && !i_ex.memread) begin
        o_sel = CTRL_EX;
      end else if (trk_hit(i_mem, i_src)) begin
        o_sel = CTRL_MEM;
      end else if (trk_hit(i_wb, i_src)) begin
        o_sel = CTRL_WB;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : ID-stage hazard responder. Tracks destinations of the
//               instructions in EX/MEM/WB, produces rs/rt forwarding selects,
//               inserts one bubble per load-use dependency, holds on
//               mem_busy and flushes on a taken branch/jump in EX.
//               Optional macro HAZARD_CHECK_EN enables the sticky probe
//               cross-check (hazard_err); otherwise hazard_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RW   = HZ_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [16:0]   instr_top,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] id_dst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          ex_taken,
  input  logic          mem_busy,
  input  logic [RW-1:0] rs_probe,
  input  logic [RW-1:0] rt_probe,
  output logic [1:0]    ctrl_rs,
  output logic [1:0]    ctrl_rt,
  output logic          if_we,
  output logic          id_we,
  output logic          id_stage_reset,
  output logic          if_flush,
  output logic          hazard_err
);

  localparam int c_unused_nreg = NREG;

  logic [RW-1:0] w_id_rs;
  logic [RW-1:0] w_id_rt;
  trk_entry_t    w_id_entry;
  trk_entry_t    r_ex;
  trk_entry_t    r_mem;
  trk_entry_t    r_wb;
  hz_state_e     r_state;

  logic w_lu_rs;
  logic w_lu_rt;
  logic w_load_use;
  logic w_advance;
  logic w_flush;
  logic w_bubble;

  assign w_id_rs = instr_top[10:6];
  assign w_id_rt = instr_top[5:1];

  // Decode summary of the ID instruction as it would enter EX
  always_comb begin
    w_id_entry          = c_trk_empty;
    w_id_entry.valid    = 1'b1;
    w_id_entry.dst      = id_dst;
    w_id_entry.regwrite = id_regwrite;
    w_id_entry.memread  = id_memread;
`ifdef HAZARD_CHECK_EN
    w_id_entry.rs       = w_id_rs;
    w_id_entry.rt       = w_id_rt;
`endif
  end

  // Load in EX whose result a used, non-zero ID source needs
  assign w_lu_rs = id_uses_rs && (w_id_rs != '0) && r_ex.valid && r_ex.memread &&
                   r_ex.regwrite && (r_ex.dst == w_id_rs);
  assign w_lu_rt = id_uses_rt && (w_id_rt != '0) && r_ex.valid && r_ex.memread &&
                   r_ex.regwrite && (r_ex.dst == w_id_rt);
  assign w_load_use = w_lu_rs || w_lu_rt;

  // Cycle priority: mem_busy holds everything, then taken flush, then bubble.
  // The state guard keeps one dependency from ever costing two bubbles.
  assign w_advance = !mem_busy;
  assign w_flush   = !mem_busy && ex_taken;
  assign w_bubble  = !mem_busy && !ex_taken && w_load_use && (r_state != HZ_BUBBLE);

  // Destination tracker: shifts on every non-busy edge, EX gets a hole on bubble/flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= c_trk_empty;
      r_mem <= c_trk_empty;
      r_wb  <= c_trk_empty;
    end else if (w_advance) begin
      r_ex  <= (w_flush || w_bubble) ? c_trk_empty : w_id_entry;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // Stall FSM: records hold and bubble cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HZ_RUN;
    end else if (mem_busy) begin
      r_state <= HZ_HOLD;
    end else if (ex_taken) begin
      r_state <= HZ_RUN;
    end else if (w_bubble) begin
      r_state <= HZ_BUBBLE;
    end else begin
      r_state <= HZ_RUN;
    end
  end

  // Pipeline enables; reset forces the free-running values immediately
  always_comb begin
    if_we          = 1'b1;
    id_we          = 1'b1;
    id_stage_reset = 1'b0;
    if_flush       = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        if_we = 1'b0;
        id_we = 1'b0;
      end else if (ex_taken) begin
        if_flush       = 1'b1;
        id_stage_reset = 1'b1;
      end else if (w_bubble) begin
        if_we          = 1'b0;
        id_we          = 1'b0;
        id_stage_reset = 1'b1;
      end
    end
  end

  hazard_fwd_sel u_fwd_rs (
    .i_src (w_id_rs),
    .i_use (id_uses_rs),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (ctrl_rs)
  );

  hazard_fwd_sel u_fwd_rt (
    .i_src (w_id_rt),
    .i_use (id_uses_rt),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (ctrl_rt)
  );

`ifdef HAZARD_CHECK_EN
  logic r_hazard_err;
  logic w_unused;
  assign w_unused = ^{instr_top[16:11], instr_top[0]};

  // Sticky cross-check of id_stage's EX operands against the tracked ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hazard_err <= 1'b0;
    end else if (w_advance && r_ex.valid &&
                 ((rs_probe != r_ex.rs) || (rt_probe != r_ex.rt))) begin
      r_hazard_err <= 1'b1;
    end
  end

  assign hazard_err = r_hazard_err;
`else
  logic w_unused;
  assign w_unused   = ^{instr_top[16:11], instr_top[0], rs_probe, rt_probe};
  assign hazard_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed self-checking bench for hazard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] instr_top;
  logic        id_uses_rs, id_uses_rt;
  logic [4:0]  id_dst;
  logic        id_regwrite, id_memread;
  logic        ex_taken, mem_busy;
  logic [4:0]  rs_probe, rt_probe;
  logic [1:0]  ctrl_rs, ctrl_rt;
  logic        if_we, id_we, id_stage_reset, if_flush, hazard_err;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_unit dut (
    .clk            (clk),
    .reset          (reset),
    .instr_top      (instr_top),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_dst         (id_dst),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .ex_taken       (ex_taken),
    .mem_busy       (mem_busy),
    .rs_probe       (rs_probe),
    .rt_probe       (rt_probe),
    .ctrl_rs        (ctrl_rs),
    .ctrl_rt        (ctrl_rt),
    .if_we          (if_we),
    .id_we          (id_we),
    .id_stage_reset (id_stage_reset),
    .if_flush       (if_flush),
    .hazard_err     (hazard_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] dst, input logic rw, input logic mr);
    instr_top   = {6'd0, rs, rt, 1'b0};
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_dst      = dst;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    ex_taken = 1'b0;
    mem_busy = 1'b0;
    rs_probe = '0;
    rt_probe = '0;
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick; tick;
    check_eq("rst_ctrl_rs", ctrl_rs, 2'd0);
    check_eq("rst_ctrl_rt", ctrl_rt, 2'd0);
    check_eq("rst_if_we", if_we, 1'b1);
    check_eq("rst_id_we", id_we, 1'b1);
    check_eq("rst_id_rst", id_stage_reset, 1'b0);
    check_eq("rst_if_flush", if_flush, 1'b0);
    check_eq("rst_err", hazard_err, 1'b0);
    reset = 1'b0;

    // add r3,r1,r2 then add r4,r3,r1
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick;
    set_id(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    settle;
    check_eq("fwd_ex_rs", ctrl_rs, 2'd1);
    check_eq("fwd_ex_rt", ctrl_rt, 2'd0);
    check_eq("fwd_ex_idwe", id_we, 1'b1);
    tick;
    check_eq("fwd_mem_rs", ctrl_rs, 2'd2);
    tick;
    check_eq("fwd_wb_rs", ctrl_rs, 2'd3);
    set_id(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    settle;
    check_eq("fwd_youngest", ctrl_rs, 2'd1);
    set_id(5'd1, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    settle;
    check_eq("fwd_nouse_rs", ctrl_rs, 2'd0);
    check_eq("fwd_rt_ex", ctrl_rt, 2'd1);

    // Writer of r0 in EX, reader of r0 in ID
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick;
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    settle;
    check_eq("r0_ctrl", ctrl_rs, 2'd0);
    check_eq("r0_idwe", id_we, 1'b1);
    check_eq("r0_idrst", id_stage_reset, 1'b0);

    // lw r5 then add r6,r5,r0
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick;
    set_id(5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    settle;
    check_eq("lu_idwe", id_we, 1'b0);
    check_eq("lu_idrst", id_stage_reset, 1'b1);
    check_eq("lu_ifwe", if_we, 1'b0);
    check_eq("lu_flush", if_flush, 1'b0);
    check_eq("lu_ctrl", ctrl_rs, 2'd0);
    tick;
    check_eq("lu_after_ctrl", ctrl_rs, 2'd2);
    check_eq("lu_after_idwe", id_we, 1'b1);
    check_eq("lu_after_idrst", id_stage_reset, 1'b0);
    tick;

    // Taken branch during load-use
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick;
    set_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    ex_taken = 1'b1;
    settle;
    check_eq("tk_flush", if_flush, 1'b1);
    check_eq("tk_idrst", id_stage_reset, 1'b1);
    check_eq("tk_ifwe", if_we, 1'b1);
    tick;
    ex_taken = 1'b0;
    settle;
    check_eq("tk_next_idrst", id_stage_reset, 1'b0);
    check_eq("tk_next_flush", if_flush, 1'b0);
    check_eq("tk_next_idwe", id_we, 1'b1);
    check_eq("tk_next_ctrl", ctrl_rs, 2'd2);

    // mem_busy for 3 cycles while a bubble is due
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick;
    set_id(5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    settle;
    check_eq("mb_pre_idrst", id_stage_reset, 1'b1);
    mem_busy = 1'b1;
    settle;
    check_eq("mb_ifwe", if_we, 1'b0);
    check_eq("mb_idwe", id_we, 1'b0);
    check_eq("mb_idrst", id_stage_reset, 1'b0);
    check_eq("mb_ctrl", ctrl_rs, 2'd0);
    for (int i = 0; i < 3; i++) tick;
    check_eq("mb_hold_ifwe", if_we, 1'b0);
    check_eq("mb_hold_idwe", id_we, 1'b0);
    check_eq("mb_hold_ctrl", ctrl_rs, 2'd0);
    mem_busy = 1'b0;
    settle;
    check_eq("mb_rel_idrst", id_stage_reset, 1'b1);
    check_eq("mb_rel_idwe", id_we, 1'b0);
    check_eq("mb_rel_ctrl", ctrl_rs, 2'd0);
    tick;
    check_eq("mb_done_ctrl", ctrl_rs, 2'd2);
    check_eq("mb_done_idwe", id_we, 1'b1);
    check_eq("mb_done_idrst", id_stage_reset, 1'b0);

    // Asynchronous reset in the middle of a hold
    mem_busy = 1'b1;
    tick;
    check_eq("hr_ifwe", if_we, 1'b0);
    check_eq("hr_ctrl", ctrl_rs, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_ifwe", if_we, 1'b1);
    check_eq("ar_idwe", id_we, 1'b1);
    check_eq("ar_idrst", id_stage_reset, 1'b0);
    check_eq("ar_ctrl", ctrl_rs, 2'd0);
    check_eq("ar_err", hazard_err, 1'b0);
    reset    = 1'b0;
    mem_busy = 1'b0;
    settle;
    check_eq("ar_post_idwe", id_we, 1'b1);
    check_eq("ar_post_ctrl", ctrl_rs, 2'd0);
    tick;

`ifdef HAZARD_CHECK_EN
    // EX now holds rs=9, rt=0
    rs_probe = 5'd9;
    rt_probe = 5'd0;
    set_id(5'd7, 5'd9, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    tick;
    rs_probe = 5'd7;
    rt_probe = 5'd9;
    set_id(5'd2, 5'd3, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick;
    check_eq("chk_err_ok", hazard_err, 1'b0);
    rs_probe = 5'd2;
    rt_probe = 5'd4;
    tick;
    check_eq("chk_err_bad_rt", hazard_err, 1'b1);
    rs_probe = 5'd0;
    rt_probe = 5'd0;
    tick;
    check_eq("chk_err_sticky", hazard_err, 1'b1);
`else
    rs_probe = 5'd3;
    rt_probe = 5'd3;
    tick;
    check_eq("nochk_err", hazard_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
